pwr_cntr_ctrl: RTL and testbench
================================

// Module: pwr_cntr_ctrl
// PURPOSE
//  Arbitrated read-modify-write controller for the power-counter memory (PwrCntr array).
//  - NREQ requesters each ask to increment one counter; the block serialises them onto the
//    single dir/LE/dato port with round-robin arbitration.
//  - Also provides a clear sweep that zeroes every counter.
//  - Sits between the per-domain toggle-event sources and the memory.
// PARAMETERS
//  NREQ  4   number of increment requesters
//  NDIR  1   address MSB index; address width is NDIR+1
//  NENT  3   populated counter entries (valid addresses 0..NENT-1)
//  DW    32  counter/data width
// PORTS
//  CLK      in   1             clock, all state changes on posedge
//  RSTn     in   1             synchronous reset, active low
//  req      in   NREQ          req[i]=1: increment counter at req_dir slice i; hold until ack[i]
//  req_dir  in   NREQ*(NDIR+1) packed addresses, slice i = [i*(NDIR+1) +: NDIR+1]
//  ack      out  NREQ          one-cycle pulse, request i completed
//  err      out  1             one-cycle pulse with ack: address >= NENT, no memory access made
//  ovf      out  1             one-cycle pulse with ack: counter was all-ones, left saturated
//  clr      in   1             pulse/level: zero all counters
//  clr_busy out  1             high while clear sweep runs
//  dir      out  NDIR+1        memory address
//  LE       out  1             1 = memory read (drives dato), 0 = memory write
//  dato_o   out  DW            write data to memory
//  dato_oe  out  1             drive enable for dato_o onto shared dato bus (equals ~LE)
//  dato_i   in   DW            data bus as seen by the controller
// BEHAVIOUR
//  - Reset values (RSTn=0 at posedge): state=IDLE, LE=1, dato_oe=0, dato_o=0, dir=0, ack=0,
//    err=0, ovf=0, clr_busy=0, rr pointer=0.
//  - All outputs are registered; dir, LE, dato_o and dato_oe change on the same edge, so the
//    memory sees a stable write for the whole WR cycle.
//  - FSM states: IDLE, RD, WR, ACK, CLR.
//  - IDLE:
//    - clr=1: go to CLR, dir=0, clr_busy=1. Clear has priority over req.
//    - else any req: choose winner g by round robin from ptr; latch its address.
//      - address >= NENT: go to ACK with err=1.
//      - otherwise: go to RD, dir=addr, LE=1.
//  - RD: one cycle; capture dato_i at the closing edge into rd_q.
//    Go to WR with LE=0, dato_oe=1, dato_o = (rd_q==all-ones) ? rd_q : rd_q+1. Record ovf.
//  - WR: one cycle; then go to ACK with LE=1, dato_oe=0, ack[g]=1, ovf as recorded.
//  - ACK: ack/err/ovf high for exactly this cycle; ptr=(g+1) mod NREQ; then IDLE.
//    req inputs are ignored in ACK, so a requester drops req the cycle after ack.
//  - Latency: req seen in IDLE at edge t -> RD at t+1, WR at t+2, ack at t+3; next grant no
//    earlier than t+4. Error path: ack+err at t+1.
//  - CLR: one write cycle per address; LE=0, dato_oe=1, dato_o=0, dir steps 0..NENT-1.
//    After dir=NENT-1: LE=1, dato_oe=0, clr_busy=0, back to IDLE. No acks during CLR.
//    clr asserted during CLR is ignored. Pending reqs wait and are served afterwards.
//  - Simultaneous reqs: the lowest index at or above ptr (wrapping) wins; the others stay
//    pending.
//  - Increment is DW-bit unsigned and saturates, never wraps.
//  - Reset mid-operation: abort immediately; the in-flight write may or may not have landed.
//    No ack is issued for the aborted request.
// STRUCTURE
//  - Shared package/include:
//    - state encodings (IDLE=0, RD=1, WR=2, ACK=3, CLR=4)
//    - NDIR/NENT defaults, consistent with the global NumPwrCntr/Ndir macros
//  - Sub-module pwr_rr_arb: NREQ-wide round-robin picker.
//    - Inputs: req, ptr. Outputs: one-hot grant and its index, combinational.
//  - FSM, datapath and the address range check live in pwr_cntr_ctrl.
// TESTING
//  1. Reset: RSTn=0 two cycles -> LE=1, dato_oe=0, ack=0, clr_busy=0, dir=0.
//  2. Single increment: preload counter 1 = 5, req[2]=1 with addr 1 ->
//     RD at t+1, WR with dato_o=6 at t+2, ack[2] pulse at t+3; memory[1]=6.
//  3. Fairness: req[0],req[1],req[3] all held from reset ->
//     acks in order 0,1,3 then 0 again, each ack 4 cycles apart.
//  4. Saturation: counter 0 = 32'hFFFFFFFF, req[1] on addr 0 ->
//     ack[1] with ovf=1; memory[0] stays FFFFFFFF.
//  5. Bad address: req[0] with addr 3 (NENT=3) -> ack[0]+err at t+1; LE never drops.
//  6. Clear vs request: clr and req[0] in the same cycle ->
//     clr_busy high for 3 cycles writing 0 to dir 0,1,2; then req[0] is served; memory[a]=1.

Source files
------------

// File: rtl/pwr_cntr_ctrl_pkg.sv
// Shared definitions for the power-counter read-modify-write controller:
// default geometry, FSM state encoding and a pointer-width helper.
package pwr_cntr_ctrl_pkg;

  localparam int PWR_NREQ = 4;
  localparam int PWR_NDIR = 1;   // matches Ndir: address is PWR_NDIR+1 bits
  localparam int PWR_NENT = 3;   // matches NumPwrCntr
  localparam int PWR_DW   = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_ACK  = 3'd3,
    ST_CLR  = 3'd4
  } pwr_state_e;

  // Index width for an n-way pointer, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwr_cntr_ctrl_if.sv
// Requester handshake and memory-port bundle of the power-counter controller.
interface pwr_cntr_ctrl_if import pwr_cntr_ctrl_pkg::*; #(
  parameter int NREQ = PWR_NREQ,
  parameter int NDIR = PWR_NDIR,
  parameter int DW   = PWR_DW
) ();

  // Handshake: a requester raises req[i] with a stable req_dir slice and holds both
  // until the one-cycle ack[i] pulse (err/ovf qualify that same cycle); it drops req
  // on the edge that closes the ack cycle. clr is sampled only while the block is idle.
  logic [NREQ-1:0]          req;
  logic [NREQ*(NDIR+1)-1:0] req_dir;
  logic [NREQ-1:0]          ack;
  logic                     err;
  logic                     ovf;
  logic                     clr;
  logic                     clr_busy;

  // Memory port: LE=1 read (memory drives dato), LE=0 write (controller drives dato).
  logic [NDIR:0]            dir;
  logic                     LE;
  logic [DW-1:0]            dato_o;
  logic                     dato_oe;
  logic [DW-1:0]            dato_i;

  modport master (
    input  req, req_dir, clr, dato_i,
    output ack, err, ovf, clr_busy, dir, LE, dato_o, dato_oe
  );

  modport slave (
    output req, req_dir, clr, dato_i,
    input  ack, err, ovf, clr_busy, dir, LE, dato_o, dato_oe
  );

endinterface

// File: rtl/pwr_rr_arb.sv
// Combinational round-robin picker: the lowest requesting index at or above ptr,
// wrapping, wins.
module pwr_rr_arb import pwr_cntr_ctrl_pkg::*; #(
  parameter  int NREQ = PWR_NREQ,
  localparam int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/pwr_cntr_ctrl.sv
// Arbitrated saturating read-modify-write of the PwrCntr array, plus a clear sweep
// that zeroes every populated entry. All outputs are registered.
module pwr_cntr_ctrl import pwr_cntr_ctrl_pkg::*; #(
  parameter int NREQ = PWR_NREQ,
  parameter int NDIR = PWR_NDIR,
  parameter int NENT = PWR_NENT,
  parameter int DW   = PWR_DW
) (
  input  logic            CLK,
  input  logic            RSTn,
  pwr_cntr_ctrl_if.master bus,
  output pwr_state_e      dbg_state
);

  localparam int              PW       = ptr_w(NREQ);
  localparam int              AW       = NDIR + 1;
  localparam logic [DW-1:0]   ALL_ONES = '1;
  localparam logic [AW-1:0]   LAST_DIR = AW'(NENT - 1);
  localparam logic [AW:0]     NENT_W   = (AW + 1)'(NENT);

  pwr_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_idx_q, g_idx_d;
  logic [NREQ-1:0] g_oh_q, g_oh_d;
  logic            ovf_rec_q, ovf_rec_d;
  logic [AW-1:0]   dir_q, dir_d;
  logic            le_q, le_d;
  logic            oe_q, oe_d;
  logic [DW-1:0]   dato_q, dato_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_vld;
  logic [AW-1:0]   sel_dir;
  logic            sel_ok;
  logic            rd_full;
  logic [DW-1:0]   rd_inc;

  pwr_rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    sel_dir = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_dir = sel_dir | bus.req_dir[i*AW +: AW];
    end
  end

  // Addresses past the populated entries are answered with err and never touch memory.
  assign sel_ok  = ({1'b0, sel_dir} < NENT_W);
  assign rd_full = (bus.dato_i == ALL_ONES);
  assign rd_inc  = rd_full ? bus.dato_i : bus.dato_i + DW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_idx_d   = g_idx_q;
    g_oh_d    = g_oh_q;
    ovf_rec_d = ovf_rec_q;
    dir_d     = dir_q;
    le_d      = le_q;
    oe_d      = oe_q;
    dato_d    = dato_q;
    ack_d     = '0;
    err_d     = 1'b0;
    ovf_d     = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          state_d = ST_CLR;
          dir_d   = '0;
          busy_d  = 1'b1;
          le_d    = 1'b0;
          oe_d    = 1'b1;
          dato_d  = '0;
        end else if (arb_vld) begin
          g_idx_d = arb_idx;
          g_oh_d  = arb_gnt;
          if (sel_ok) begin
            state_d = ST_RD;
            dir_d   = sel_dir;
            le_d    = 1'b1;
          end else begin
            state_d = ST_ACK;
            ack_d   = arb_gnt;
            err_d   = 1'b1;
          end
        end
      end
      ST_RD: begin
        state_d   = ST_WR;
        le_d      = 1'b0;
        oe_d      = 1'b1;
        dato_d    = rd_inc;
        ovf_rec_d = rd_full;
      end
      ST_WR: begin
        state_d = ST_ACK;
        le_d    = 1'b1;
        oe_d    = 1'b0;
        ack_d   = g_oh_q;
        ovf_d   = ovf_rec_q;
      end
      ST_ACK: begin
        // Requests are ignored here so the acked requester has time to drop req.
        state_d = ST_IDLE;
        ptr_d   = (g_idx_q == PW'(NREQ - 1)) ? '0 : g_idx_q + PW'(1);
      end
      ST_CLR: begin
        if (dir_q == LAST_DIR) begin
          state_d = ST_IDLE;
          le_d    = 1'b1;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          dir_d = dir_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      g_idx_q   <= '0;
      g_oh_q    <= '0;
      ovf_rec_q <= 1'b0;
      dir_q     <= '0;
      le_q      <= 1'b1;
      oe_q      <= 1'b0;
      dato_q    <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_idx_q   <= g_idx_d;
      g_oh_q    <= g_oh_d;
      ovf_rec_q <= ovf_rec_d;
      dir_q     <= dir_d;
      le_q      <= le_d;
      oe_q      <= oe_d;
      dato_q    <= dato_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.dir      = dir_q;
  assign bus.LE       = le_q;
  assign bus.dato_o   = dato_q;
  assign bus.dato_oe  = oe_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.ovf      = ovf_q;
  assign bus.clr_busy = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pwr_cntr_ctrl.sv
// Bench for pwr_cntr_ctrl: transaction-level reference model predicting the per-cycle
// outputs, directed scenarios with literal expectations, then randomized traffic.
module tb_pwr_cntr_ctrl;
  import pwr_cntr_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int NDIR = 1;
  localparam int NENT = 3;
  localparam int DW   = 32;
  localparam int AW   = NDIR + 1;
  localparam logic [DW-1:0] MAXV = '1;

  // clock / reset
  logic       clk;
  logic       rst_n;
  pwr_state_e dbg_state;

  pwr_cntr_ctrl_if #(.NREQ(NREQ), .NDIR(NDIR), .DW(DW)) bus ();

  pwr_cntr_ctrl #(.NREQ(NREQ), .NDIR(NDIR), .NENT(NENT), .DW(DW)) dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // environment memory, preloadable while the controller is held in reset
  logic [DW-1:0] mem [NENT];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_val;
    else if (!bus.LE && int'(bus.dir) < NENT) mem[bus.dir] <= bus.dato_o;
  end

  assign bus.dato_i = bus.LE ? ((int'(bus.dir) < NENT) ? mem[bus.dir] : '0) : bus.dato_o;

  // scoreboard
  typedef struct packed {
    pwr_state_e      st;
    logic [AW-1:0]   dir;
    logic            le;
    logic            oe;
    logic [DW-1:0]   dato;
    logic [NREQ-1:0] ack;
    logic            err;
    logic            ovf;
    logic            busy;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NENT];
  int            m_ptr;
  logic [AW-1:0] m_dir;
  logic [DW-1:0] m_dato;
  int            n_cmp, n_bad, cyc;
  int            ack_log[$];
  int            ack_cyc[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  function automatic exp_t mk(input pwr_state_e st, input logic [AW-1:0] d, input logic le,
                              input logic [DW-1:0] v, input logic [NREQ-1:0] a,
                              input logic er, input logic ov, input logic bz);
    exp_t e;
    e.st = st; e.dir = d; e.le = le; e.oe = ~le; e.dato = v;
    e.ack = a; e.err = er; e.ovf = ov; e.busy = bz;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    return mk(ST_IDLE, m_dir, 1'b1, m_dato, '0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Decide the next transaction from the inputs about to be sampled, if the block is free.
  task automatic model_step();
    int            g;
    logic [AW-1:0] a;
    logic [DW-1:0] old_v, new_v;
    logic [NREQ-1:0] oh;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 0; m_dir = '0; m_dato = '0;
      return;
    end
    if (exp_q.size() != 0) return;
    if (bus.clr) begin
      for (int k = 0; k < NENT; k++) begin
        exp_q.push_back(mk(ST_CLR, AW'(k), 1'b0, '0, '0, 1'b0, 1'b0, 1'b1));
        ref_mem[k] = '0;
      end
      m_dir = AW'(NENT - 1); m_dato = '0;
      exp_q.push_back(idle_exp());
      return;
    end
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (g < 0 && bus.req[i]) g = i;
    end
    if (g < 0) return;
    oh = '0; oh[g] = 1'b1;
    a = bus.req_dir[g*AW +: AW];
    if (int'(a) >= NENT) begin
      exp_q.push_back(mk(ST_ACK, m_dir, 1'b1, m_dato, oh, 1'b1, 1'b0, 1'b0));
    end else begin
      old_v = ref_mem[a];
      new_v = (old_v == MAXV) ? old_v : old_v + 1;
      ref_mem[a] = new_v;
      exp_q.push_back(mk(ST_RD,  a, 1'b1, m_dato, '0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(ST_WR,  a, 1'b0, new_v,  '0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(ST_ACK, a, 1'b1, new_v,  oh, 1'b0, old_v == MAXV, 1'b0));
      m_dir = a; m_dato = new_v;
    end
    exp_q.push_back(idle_exp());
    m_ptr = (g + 1) % NREQ;
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = idle_exp();
    chk("state",    DW'(dbg_state),    DW'(e.st));
    chk("dir",      DW'(bus.dir),      DW'(e.dir));
    chk("LE",       DW'(bus.LE),       DW'(e.le));
    chk("dato_oe",  DW'(bus.dato_oe),  DW'(e.oe));
    chk("dato_o",   bus.dato_o,        e.dato);
    chk("ack",      DW'(bus.ack),      DW'(e.ack));
    chk("err",      DW'(bus.err),      DW'(e.err));
    chk("ovf",      DW'(bus.ovf),      DW'(e.ovf));
    chk("clr_busy", DW'(bus.clr_busy), DW'(e.busy));
  endtask

  // driver: one clock, model first, then compare and let acked requesters drop
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i]) begin
        ack_log.push_back(i);
        ack_cyc.push_back(cyc);
        bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic raise(input int i, input int a);
    bus.req_dir[i*AW +: AW] = AW'(a);
    bus.req[i] = 1'b1;
  endtask

  task automatic reset_and_load(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                input logic [DW-1:0] v2);
    bus.req = '0;
    bus.clr = 1'b0;
    rst_n   = 1'b0;
    cycle();
    for (int k = 0; k < NENT; k++) begin
      pl_en   = 1'b1;
      pl_addr = AW'(k);
      pl_val  = (k == 0) ? v0 : (k == 1) ? v1 : v2;
      ref_mem[k] = pl_val;
      cycle();
    end
    pl_en = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_ptr = 0; m_dir = '0; m_dato = '0;
    for (int k = 0; k < NENT; k++) ref_mem[k] = '0;
    rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_val = '0;
    bus.req = '0; bus.req_dir = '0; bus.clr = 1'b0;

    // reset values
    cycle();
    cycle();
    chk("rst_LE",    DW'(bus.LE),       32'd1);
    chk("rst_oe",    DW'(bus.dato_oe),  32'd0);
    chk("rst_ack",   DW'(bus.ack),      32'd0);
    chk("rst_busy",  DW'(bus.clr_busy), 32'd0);
    chk("rst_dir",   DW'(bus.dir),      32'd0);

    // single increment: counter 1 = 5 via requester 2
    reset_and_load(32'd0, 32'd5, 32'd0);
    raise(2, 1);
    cycle();
    chk("inc_rd_state", DW'(dbg_state), DW'(ST_RD));
    chk("inc_rd_dir",   DW'(bus.dir),   32'd1);
    cycle();
    chk("inc_wr_LE",    DW'(bus.LE),    32'd0);
    chk("inc_wr_data",  bus.dato_o,     32'd6);
    cycle();
    chk("inc_ack",      DW'(bus.ack),   32'b0100);
    cycle();
    chk("inc_mem",      mem[1],         32'd6);

    // fairness: requesters 0,1,3 held from reset
    reset_and_load(32'd0, 32'd0, 32'd0);
    ack_log.delete(); ack_cyc.delete();
    raise(0, 0); raise(1, 1); raise(3, 2);
    for (int n = 0; n < 16; n++) begin
      cycle();
      if (!bus.req[0]) raise(0, 0);
      if (!bus.req[1]) raise(1, 1);
      if (!bus.req[3]) raise(3, 2);
    end
    chk("fair_count", DW'(ack_log.size()), 32'd4);
    if (ack_log.size() >= 4) begin
      chk("fair_0", DW'(ack_log[0]), 32'd0);
      chk("fair_1", DW'(ack_log[1]), 32'd1);
      chk("fair_2", DW'(ack_log[2]), 32'd3);
      chk("fair_3", DW'(ack_log[3]), 32'd0);
      for (int k = 0; k < 3; k++) chk("fair_gap", DW'(ack_cyc[k+1] - ack_cyc[k]), 32'd4);
    end

    // saturation (also aborts the fairness traffic mid-flight)
    reset_and_load(MAXV, 32'd10, 32'd20);
    raise(1, 0);
    cycle();
    cycle();
    chk("sat_wr_data", bus.dato_o,    MAXV);
    cycle();
    chk("sat_ack",     DW'(bus.ack),  32'b0010);
    chk("sat_ovf",     DW'(bus.ovf),  32'd1);
    cycle();
    chk("sat_mem",     mem[0],        MAXV);

    // bad address
    raise(0, 3);
    cycle();
    chk("bad_ack", DW'(bus.ack), 32'b0001);
    chk("bad_err", DW'(bus.err), 32'd1);
    chk("bad_LE",  DW'(bus.LE),  32'd1);
    cycle();
    chk("bad_ack_drop", DW'(bus.ack), 32'd0);
    chk("bad_LE2",      DW'(bus.LE),  32'd1);

    // clear against a simultaneous request; a second clr during the sweep is ignored
    bus.clr = 1'b1;
    raise(0, 2);
    cycle();
    bus.clr = 1'b0;
    chk("clr_busy0", DW'(bus.clr_busy), 32'd1);
    chk("clr_dir0",  DW'(bus.dir),      32'd0);
    chk("clr_LE0",   DW'(bus.LE),       32'd0);
    chk("clr_dat0",  bus.dato_o,        32'd0);
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    chk("clr_dir1",  DW'(bus.dir),      32'd1);
    cycle();
    chk("clr_dir2",  DW'(bus.dir),      32'd2);
    chk("clr_busy2", DW'(bus.clr_busy), 32'd1);
    cycle();
    chk("clr_done",  DW'(bus.clr_busy), 32'd0);
    chk("clr_LE",    DW'(bus.LE),       32'd1);
    cycle();
    chk("clr_req_rd", DW'(dbg_state),   DW'(ST_RD));
    cycle();
    cycle();
    chk("clr_req_ack", DW'(bus.ack),    32'b0001);
    cycle();
    chk("clr_mem0", mem[0], 32'd0);
    chk("clr_mem1", mem[1], 32'd0);
    chk("clr_mem2", mem[2], 32'd1);

    // randomized traffic near saturation, with one mid-operation reset
    reset_and_load(MAXV - 1, MAXV, DW'($urandom));
    for (int n = 0; n < 1200; n++) begin
      if (n == 600) reset_and_load(DW'($urandom), MAXV - 2, DW'($urandom_range(0, 100)));
      bus.clr = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] && $urandom_range(0, 2) == 0) raise(i, $urandom_range(0, 3));
      end
      cycle();
    end
    bus.clr = 1'b0;
    for (int n = 0; n < 60 && (bus.req != '0 || exp_q.size() != 0); n++) cycle();
    chk("drain_pending", DW'(bus.req), 32'd0);
    repeat (2) cycle();
    for (int k = 0; k < NENT; k++) chk("final_mem", mem[k], ref_mem[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
